// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix coprocessor: element geometry, the
// loader state encoding and the row-major slot-to-bit mapping that the
// compute units also use to unpack operand buses.
package coproc_pkg;

   localparam int EW    = 8;
   localparam int MAX_N = 5;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HOLD = 2'd1,
      DROP = 2'd2
   } state_t;

   // Element k of an n x n matrix lives at [lsb +: ew]. Element 0 sits in
   // the most significant slot, so a00 is the top byte of the packed bus.
   function automatic int slot_lsb(input int k, input int n, input int ew = EW);
      return ew * (n * n - 1 - k);
   endfunction

endpackage

// File: rtl/mat_stream_loader.sv
// Packs a row-major element stream into one wide matrix word for the
// compute units. Frames that end too early or run too long are reported
// with a one-cycle err pulse and discarded, and the loader resynchronises
// on the next in_last.
module mat_stream_loader #(
   parameter int N  = 3,
   parameter int EW = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [EW-1:0]      in_data,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic [EW*N*N-1:0]  out_m,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               err
);

   import coproc_pkg::*;

   localparam int NE = N * N;
   localparam int MW = EW * NE;
   localparam int IW = $clog2(NE);

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q,   idx_d;
   logic [MW-1:0]   buf_q,   buf_d;
   logic            err_q,   err_d;

   logic            inXfer;
   logic            lastSlot;

   // Handshake outputs depend only on the registered state, so neither
   // in_valid nor out_ready can reach an output combinationally.
   assign in_ready  = (state_q != HOLD);
   assign out_valid = (state_q == HOLD);
   assign out_m     = buf_q;
   assign err       = err_q;

   assign inXfer   = in_valid && in_ready;
   assign lastSlot = (idx_q == IW'(NE - 1));

   // Next-state decode: place accepted elements, judge framing on in_last
   // and on the final slot, and release the held matrix on handshake.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      err_d   = 1'b0;

      case (state_q)
         FILL: begin
            if (inXfer) begin
               for (int k = 0; k < NE; k++) begin
                  if (idx_q == IW'(k)) begin
                     buf_d[slot_lsb(k, N, EW) +: EW] = in_data;
                  end
               end
               if (lastSlot) begin
                  idx_d = '0;
                  if (in_last) begin
                     state_d = HOLD;
                  end else begin
                     err_d   = 1'b1;
                     buf_d   = '0;
                     state_d = DROP;
                  end
               end else if (in_last) begin
                  err_d = 1'b1;
                  idx_d = '0;
                  buf_d = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end

         DROP: begin
            if (inXfer && in_last) begin
               state_d = FILL;
               idx_d   = '0;
            end
         end

         HOLD: begin
            if (out_ready) begin
               state_d = FILL;
               idx_d   = '0;
            end
         end

         default: begin
            state_d = FILL;
            idx_d   = '0;
         end
      endcase
   end

   // State register; reset wins over any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         idx_q   <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_mat_stream_loader.sv
// Bench for mat_stream_loader: a 3x3 and a 2x2 instance driven by directed
// frames and a random phase, both tracked by a frame-level reference model.
module tb_mat_stream_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  d3 = '0, d2 = '0;
   logic        v3 = 1'b0, l3 = 1'b0, or3 = 1'b1;
   logic        v2 = 1'b0, l2 = 1'b0, or2 = 1'b0;
   logic        rdy3, ov3, err3, rdy2, ov2, err2;
   logic [71:0] m3;
   logic [31:0] m2;

   int checks   = 0;
   int failures = 0;

   // Reference model: elements accepted in the current frame, drop/hold
   // status, expected matrix word and expected err pulse per instance.
   int           cnt[2];
   bit           dropping[2];
   bit           holding[2];
   bit           errE[2];
   logic [199:0] mat[2];

   always #5 clk = ~clk;

   mat_stream_loader #(.N(3), .EW(8)) dut3 (
      .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_last(l3),
      .in_ready(rdy3), .out_m(m3), .out_valid(ov3), .out_ready(or3), .err(err3)
   );

   mat_stream_loader #(.N(2), .EW(8)) dut2 (
      .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_last(l2),
      .in_ready(rdy2), .out_m(m2), .out_valid(ov2), .out_ready(or2), .err(err2)
   );

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic checkMat(input string tag, input logic [199:0] obs, input logic [199:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelStep(input int i, input bit v, input logic [7:0] d, input bit l, input bit ord);
      int ne = (i == 0) ? 9 : 4;
      int sh;
      errE[i] = 1'b0;
      if (rst) begin
         cnt[i] = 0; dropping[i] = 1'b0; holding[i] = 1'b0; mat[i] = '0;
      end else if (holding[i]) begin
         if (ord) begin
            holding[i] = 1'b0;
            cnt[i]     = 0;
         end
      end else if (v) begin
         if (dropping[i]) begin
            if (l) dropping[i] = 1'b0;
         end else begin
            sh     = 8 * (ne - 1 - cnt[i]);
            mat[i] = (mat[i] & ~(200'hFF << sh)) | (200'(d) << sh);
            cnt[i]++;
            if (cnt[i] == ne && l) begin
               holding[i] = 1'b1; cnt[i] = 0;
            end else if (cnt[i] == ne) begin
               errE[i] = 1'b1; dropping[i] = 1'b1; cnt[i] = 0; mat[i] = '0;
            end else if (l) begin
               errE[i] = 1'b1; cnt[i] = 0; mat[i] = '0;
            end
         end
      end
   endtask

   task automatic checkOutput();
      checkBit("n3 in_ready",  rdy3, !holding[0]);
      checkBit("n3 out_valid", ov3,  holding[0]);
      checkBit("n3 err",       err3, errE[0]);
      checkMat("n3 out_m",     200'(m3), 200'(mat[0][71:0]));
      checkBit("n2 in_ready",  rdy2, !holding[1]);
      checkBit("n2 out_valid", ov2,  holding[1]);
      checkBit("n2 err",       err2, errE[1]);
      checkMat("n2 out_m",     200'(m2), 200'(mat[1][31:0]));
   endtask

   // One clock: update the model from the pre-edge inputs, then compare.
   task automatic applyStimulus();
      modelStep(0, v3, d3, l3, or3);
      modelStep(1, v2, d2, l2, or2);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // Offer one element to instance i until it is taken, with a bound.
   task automatic sendElem(input int i, input logic [7:0] d, input bit l);
      bit done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
         if (i == 0) begin v3 = 1'b1; d3 = d; l3 = l; end
         else        begin v2 = 1'b1; d2 = d; l2 = l; end
         done = !holding[i];
         applyStimulus();
      end
      v3 = 1'b0; l3 = 1'b0; v2 = 1'b0; l2 = 1'b0;
      checks++;
      assert (done) else begin
         failures++;
         $error("[TB] FAIL accept timeout: observed %0b expected 1", done);
      end
   endtask

   task automatic sendFrame3(input logic [7:0] base);
      for (int k = 0; k < 9; k++) sendElem(0, base + 8'(k), k == 8);
   endtask

   initial begin
      logic [7:0] bp [9];
      bp = '{8'hF7, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};

      $display("[TB] reset");
      rst = 1'b1;
      applyStimulus();
      applyStimulus();
      rst = 1'b0;
      checkMat("reset out_m", 200'(m3), 200'h0);
      checkBit("reset in_ready", rdy3, 1'b1);

      $display("[TB] basic frame");
      sendFrame3(8'h01);
      checkMat("basic out_m", 200'(m3), 200'h010203040506070809);
      checkBit("basic out_valid", ov3, 1'b1);
      checkBit("basic err", err3, 1'b0);
      applyStimulus();
      checkBit("basic ready after handshake", rdy3, 1'b1);

      $display("[TB] backpressure");
      or3 = 1'b0;
      sendFrame3(8'h31);
      v3 = 1'b1; d3 = 8'hAA;
      for (int c = 0; c < 6; c++) begin
         applyStimulus();
         checkMat("stall out_m", 200'(m3), 200'h313233343536373839);
         checkBit("stall in_ready", rdy3, 1'b0);
      end
      v3 = 1'b0;
      or3 = 1'b1;
      for (int k = 0; k < 9; k++) sendElem(0, bp[k], k == 8);
      checkMat("signed frame out_m", 200'(m3), 200'hF7807F00FF01020304);

      $display("[TB] short frame");
      for (int k = 0; k < 4; k++) sendElem(0, 8'h51 + 8'(k), k == 3);
      checkBit("short err", err3, 1'b1);
      checkBit("short out_valid", ov3, 1'b0);
      sendFrame3(8'h11);
      checkMat("after short out_m", 200'(m3), 200'h111213141516171819);

      $display("[TB] long frame");
      for (int k = 0; k < 11; k++) begin
         sendElem(0, 8'h61 + 8'(k), k == 10);
         if (k == 8) checkBit("long err", err3, 1'b1);
      end
      sendFrame3(8'h71);
      checkMat("after long out_m", 200'(m3), 200'h717273747576777879);

      $display("[TB] reset mid-frame");
      for (int k = 0; k < 5; k++) sendElem(0, 8'h81 + 8'(k), 1'b0);
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      checkMat("midreset out_m", 200'(m3), 200'h0);
      checkBit("midreset out_valid", ov3, 1'b0);
      sendFrame3(8'h21);
      checkMat("after reset out_m", 200'(m3), 200'h212223242526272829);

      $display("[TB] N=2 with bubbles");
      or2 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sendElem(1, 8'h0A + 8'(k), k == 3);
         if (k != 3) applyStimulus();
      end
      checkMat("n2 bubbles out_m", 200'(m2), 200'h0A0B0C0D);
      for (int k = 0; k < 4; k++) sendElem(1, 8'h0A + 8'(k), k == 3);
      checkMat("n2 gapfree out_m", 200'(m2), 200'h0A0B0C0D);

      $display("[TB] random traffic");
      for (int c = 0; c < 600; c++) begin
         v3  = ($urandom_range(0, 3) != 0);
         d3  = 8'($urandom);
         l3  = (cnt[0] == 8) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 11) == 0);
         or3 = ($urandom_range(0, 2) != 0);
         v2  = ($urandom_range(0, 3) != 0);
         d2  = 8'($urandom);
         l2  = (cnt[1] == 3) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
         or2 = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 249) == 0);
         applyStimulus();
      end
      rst = 1'b0; v3 = 1'b0; v2 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
